// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer for the Lab4 MIPS core.
// Fetches over a req/ack handshake and presents instructions under valid/ready.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic [31:0] branchAddress,
   input  logic        jump_en,
   input  logic [25:0] jump_index,
   input  logic        jr_en,
   input  logic [31:0] jr_addr,
   output logic        addr_err,
   output logic [31:0] retire_count
);

   typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        fetch_done;
   logic        retire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = REQ;
         REQ:     if (imem_ack)    state_next = VALID;
         VALID:   if (instr_ready) state_next = REQ;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      imem_req    = (state == REQ);
      instr_valid = (state == VALID);
      fetch_done  = (state == REQ)   && imem_ack;
      retire      = (state == VALID) && instr_ready;
   end

   assign pc_plus4  = pc + 32'd4;
   assign pc_out    = pc;
   assign imem_addr = pc;

   // Redirect priority: JR over J/JAL over taken branch over sequential.
   always_comb begin
      if (jr_en) begin
         next_pc = {jr_addr[31:2], 2'b00};
      end else if (jump_en) begin
         next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      end else if (branchAddress != 32'd0) begin
         next_pc = pc_plus4 + branchAddress;
      end else begin
         next_pc = pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         instr        <= 32'd0;
         addr_err     <= 1'b0;
         retire_count <= 32'd0;
      end else begin
         if (fetch_done) begin
            instr <= imem_rdata;
         end
         if (retire) begin
            pc           <= next_pc;
            retire_count <= retire_count + 32'd1;
            if (jr_en && (jr_addr[1:0] != 2'b00)) begin
               addr_err <= 1'b1;
            end
         end
      end
   end

endmodule
